// File: rtl/aes_stub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_stub_pkg
// Purpose  : Shared FSM states, round-key and byte-rotation helpers for the
//            stand-in iterative cipher core.
// Revision : 1.0 - initial release
// ============================================================================
package aes_stub_pkg;

  localparam int ROT_BYTES  = 1;
  localparam int c_rot_bits = 8 * ROT_BYTES;

  // Helpers work on a fixed wide carrier; callers pass their real width and
  // cast the result back down. Supports DATA_W up to c_max_w.
  localparam int c_max_w = 1024;

  typedef logic [c_max_w-1:0] wide_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // Key XOR a repeated byte (idx+1); every byte lane is identical, so the low
  // DATA_W bits are the correct round key for any DATA_W.
  function automatic wide_t round_key(input wide_t key, input logic [7:0] idx);
    return key ^ {(c_max_w / 8){8'(idx + 8'd1)}};
  endfunction

  // Rotate the low w bits left by one byte (top byte wraps to the bottom).
  function automatic wide_t rotl8(input wide_t v, input int w);
    wide_t r;
    int    k;
    r = '0;
    for (int i = 0; i < c_max_w; i++) begin
      if (i < w) begin
        k    = (i >= c_rot_bits) ? (i - c_rot_bits) : (i + w - c_rot_bits);
        r[i] = v[k];
      end
    end
    return r;
  endfunction

  // Rotate the low w bits right by one byte (bottom byte wraps to the top).
  function automatic wide_t rotr8(input wide_t v, input int w);
    wide_t r;
    int    k;
    r = '0;
    for (int i = 0; i < c_max_w; i++) begin
      if (i < w) begin
        k    = (i + c_rot_bits < w) ? (i + c_rot_bits) : (i + c_rot_bits - w);
        r[i] = v[k];
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_stub_round.sv
`default_nettype none
// ============================================================================
// Module   : aes_stub_round
// Purpose  : One combinational keyed round; decrypt is the exact inverse step.
// Revision : 1.0 - initial release
// ============================================================================
module aes_stub_round
  import aes_stub_pkg::*;
#(
  parameter int DATA_W = 128
) (
  input  logic [DATA_W-1:0] s_in,
  input  logic [DATA_W-1:0] rk,
  input  logic              dec,
  output logic [DATA_W-1:0] s_out
);

  logic [DATA_W-1:0] w_enc;
  logic [DATA_W-1:0] w_dec;

  assign w_enc = DATA_W'(rotl8(wide_t'(s_in ^ rk), DATA_W));
  assign w_dec = DATA_W'(rotr8(wide_t'(s_in), DATA_W)) ^ rk;
  assign s_out = dec ? w_dec : w_enc;

endmodule
`default_nettype wire

// File: rtl/aes_iter_core_stub.sv
`default_nettype none
// ============================================================================
// Module   : aes_iter_core_stub
// Purpose  : Cycle-accurate iterative cipher stand-in, one round per clock,
//            valid/ready in and out, completed-operation counter.
// Revision : 1.0 - initial release
// ============================================================================
module aes_iter_core_stub
  import aes_stub_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int ROUNDS = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_enc_dec,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] in_key,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_enc_dec,
  output logic              busy,
  output logic [CNT_W-1:0]  ops_done
);

  localparam logic [7:0] c_last_rnd = 8'(ROUNDS - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [7:0]        r_rnd;
  logic [DATA_W-1:0] r_s;
  logic [DATA_W-1:0] r_key;
  logic              r_dec;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_enc_dec;
  logic              r_out_valid;
  logic [CNT_W-1:0]  r_ops_done;

  logic              w_accept;
  logic              w_last;
  logic              w_handoff;
  logic [7:0]        w_rk_idx;
  logic [DATA_W-1:0] w_rk;
  logic [DATA_W-1:0] w_s_nxt;

  // Decrypt walks the key schedule backwards.
  assign w_rk_idx = r_dec ? (c_last_rnd - r_rnd) : r_rnd;
  assign w_rk     = DATA_W'(round_key(wide_t'(r_key), w_rk_idx));

  aes_stub_round #(
    .DATA_W (DATA_W)
  ) u_round (
    .s_in  (r_s),
    .rk    (w_rk),
    .dec   (r_dec),
    .s_out (w_s_nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    busy        = 1'b0;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    w_handoff   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (r_rnd == c_last_rnd) begin
          w_last      = 1'b1;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        busy = 1'b1;
        if (out_ready) begin
          w_handoff   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rnd         <= '0;
      r_s           <= '0;
      r_key         <= '0;
      r_dec         <= 1'b0;
      r_out_data    <= '0;
      r_out_enc_dec <= 1'b0;
      r_out_valid   <= 1'b0;
      r_ops_done    <= '0;
    end else begin
      if (w_accept) begin
        r_s   <= in_data;
        r_key <= in_key;
        r_dec <= in_enc_dec;
        r_rnd <= '0;
      end else if (r_state == ST_RUN) begin
        r_s   <= w_s_nxt;
        r_rnd <= r_rnd + 8'd1;
      end
      // Result is taken straight from the final round so it is visible on the
      // same edge that applies that round.
      if (w_last) begin
        r_out_data    <= w_s_nxt;
        r_out_enc_dec <= r_dec;
        r_out_valid   <= 1'b1;
      end
      if (w_handoff) begin
        r_out_valid <= 1'b0;
        r_ops_done  <= r_ops_done + CNT_W'(1);
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_enc_dec = r_out_enc_dec;
  assign ops_done    = r_ops_done;

endmodule
`default_nettype wire

// File: tb/tb_aes_iter_core_stub.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_iter_core_stub
// Purpose  : Directed, table-driven self-checking bench for aes_iter_core_stub.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_iter_core_stub;

  localparam int NI = 4;
  localparam int TO = 400;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Index 0: ROUNDS=1, 1: ROUNDS=2, 2: defaults, 3: CNT_W=4
  logic         iv   [NI];
  logic         ir   [NI];
  logic         ied  [NI];
  logic         ov   [NI];
  logic         ordy [NI];
  logic         oed  [NI];
  logic         bsy  [NI];
  logic [127:0] idat [NI];
  logic [127:0] ikey [NI];
  logic [127:0] odat [NI];
  logic [15:0]  ops0, ops1, ops2;
  logic [3:0]   ops3;

  logic        s_iv, s_ir, s_ied, s_ov, s_ordy, s_oed, s_bsy;
  logic [15:0] s_idat, s_ikey, s_odat, s_ops;

  int total = 0;
  int bad   = 0;

  aes_iter_core_stub #(.DATA_W(128), .ROUNDS(1), .CNT_W(16)) u_r1 (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]), .in_enc_dec(ied[0]),
    .in_data(idat[0]), .in_key(ikey[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_data(odat[0]), .out_enc_dec(oed[0]), .busy(bsy[0]), .ops_done(ops0));

  aes_iter_core_stub #(.DATA_W(128), .ROUNDS(2), .CNT_W(16)) u_r2 (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]), .in_enc_dec(ied[1]),
    .in_data(idat[1]), .in_key(ikey[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_data(odat[1]), .out_enc_dec(oed[1]), .busy(bsy[1]), .ops_done(ops1));

  aes_iter_core_stub u_def (
    .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]), .in_enc_dec(ied[2]),
    .in_data(idat[2]), .in_key(ikey[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
    .out_data(odat[2]), .out_enc_dec(oed[2]), .busy(bsy[2]), .ops_done(ops2));

  aes_iter_core_stub #(.DATA_W(128), .ROUNDS(10), .CNT_W(4)) u_c4 (
    .clk(clk), .reset(reset), .in_valid(iv[3]), .in_ready(ir[3]), .in_enc_dec(ied[3]),
    .in_data(idat[3]), .in_key(ikey[3]), .out_valid(ov[3]), .out_ready(ordy[3]),
    .out_data(odat[3]), .out_enc_dec(oed[3]), .busy(bsy[3]), .ops_done(ops3));

  aes_iter_core_stub #(.DATA_W(16), .ROUNDS(2), .CNT_W(16)) u_s (
    .clk(clk), .reset(reset), .in_valid(s_iv), .in_ready(s_ir), .in_enc_dec(s_ied),
    .in_data(s_idat), .in_key(s_ikey), .out_valid(s_ov), .out_ready(s_ordy),
    .out_data(s_odat), .out_enc_dec(s_oed), .busy(s_bsy), .ops_done(s_ops));

  typedef struct {
    logic        dec;
    logic [15:0] data;
    logic [15:0] key;
    logic [15:0] exp;
  } vec_t;

  function automatic int rounds_of(input int k);
    case (k)
      0:       return 1;
      1:       return 2;
      default: return 10;
    endcase
  endfunction

  function automatic logic [15:0] ops_of(input int k);
    case (k)
      0:       return ops0;
      1:       return ops1;
      2:       return ops2;
      default: return {12'd0, ops3};
    endcase
  endfunction

  // Straight reading of the encrypt definition for 128-bit blocks.
  function automatic logic [127:0] model_enc(input logic [127:0] x, input logic [127:0] k,
                                             input int r);
    logic [127:0] s;
    s = x;
    for (int i = 0; i < r; i++) begin
      s = s ^ k ^ {16{8'(i + 1)}};
      s = {s[119:0], s[127:120]};
    end
    return s;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int k, input logic [127:0] d, input logic [127:0] key,
                      input logic dec);
    check($sformatf("ready_before_send_%0d", k), 128'(ir[k]), 128'd1);
    idat[k] = d;
    ikey[k] = key;
    ied[k]  = dec;
    iv[k]   = 1'b1;
    tick();
    iv[k]   = 1'b0;
    idat[k] = ~d;
    ikey[k] = ~key;
    ied[k]  = ~dec;
  endtask

  task automatic wait_out(input int k, output int lat);
    lat = 0;
    while (!ov[k] && lat < TO) begin
      tick();
      lat++;
    end
  endtask

  task automatic run(input int k, input logic [127:0] d, input logic [127:0] key,
                     input logic dec, output logic [127:0] res, output logic red,
                     output int lat);
    send(k, d, key, dec);
    wait_out(k, lat);
    check($sformatf("latency_%0d", k), 128'(lat), 128'(rounds_of(k)));
    res     = odat[k];
    red     = oed[k];
    ordy[k] = 1'b1;
    tick();
    ordy[k] = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         tbl [7];
    logic [127:0] x, kk, res, rec, expd;
    logic         red;
    int           lat, cyc, acc, hand, last;

    tbl[0] = '{1'b0, 16'h0000, 16'h0000, 16'h0303};
    tbl[1] = '{1'b0, 16'h1234, 16'h0000, 16'h1137};
    tbl[2] = '{1'b0, 16'h1234, 16'hff00, 16'heec8};
    tbl[3] = '{1'b0, 16'habcd, 16'h1234, 16'h8ee8};
    tbl[4] = '{1'b0, 16'hffff, 16'h00ff, 16'h0303};
    tbl[5] = '{1'b1, 16'h1137, 16'h0000, 16'h1234};
    tbl[6] = '{1'b1, 16'h8ee8, 16'h1234, 16'habcd};

    for (int k = 0; k < NI; k++) begin
      iv[k] = 1'b0; ied[k] = 1'b0; ordy[k] = 1'b0; idat[k] = '0; ikey[k] = '0;
    end
    s_iv = 1'b0; s_ied = 1'b0; s_ordy = 1'b0; s_idat = '0; s_ikey = '0;

    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    for (int k = 0; k < NI; k++) begin
      check($sformatf("rst_out_valid_%0d", k), 128'(ov[k]), 128'd0);
      check($sformatf("rst_out_data_%0d", k), odat[k], 128'd0);
      check($sformatf("rst_out_enc_dec_%0d", k), 128'(oed[k]), 128'd0);
      check($sformatf("rst_ops_%0d", k), 128'(ops_of(k)), 128'd0);
      check($sformatf("rst_in_ready_%0d", k), 128'(ir[k]), 128'd1);
      check($sformatf("rst_busy_%0d", k), 128'(bsy[k]), 128'd0);
    end

    // ROUNDS=1
    run(0, 128'd0, 128'd0, 1'b0, res, red, lat);
    check("r1_zero_data", res, {16{8'h01}});
    check("r1_ops", 128'(ops_of(0)), 128'd1);
    run(0, 128'h000102030405060708090a0b0c0d0e0f, 128'd0, 1'b0, res, red, lat);
    check("r1_rotl_data", res, 128'h0003020504070609080b0a0d0c0f0e01);
    run(0, 128'h0003020504070609080b0a0d0c0f0e01, 128'd0, 1'b1, res, red, lat);
    check("r1_dec_data", res, 128'h000102030405060708090a0b0c0d0e0f);
    check("r1_dec_mode", 128'(red), 128'd1);

    // ROUNDS=2, cycle by cycle
    send(1, 128'd0, 128'd0, 1'b0);
    check("r2_busy_e0", 128'(bsy[1]), 128'd1);
    check("r2_valid_e0", 128'(ov[1]), 128'd0);
    check("r2_ready_e0", 128'(ir[1]), 128'd0);
    tick();
    check("r2_busy_e1", 128'(bsy[1]), 128'd1);
    check("r2_valid_e1", 128'(ov[1]), 128'd0);
    tick();
    check("r2_valid_e2", 128'(ov[1]), 128'd1);
    check("r2_data_e2", odat[1], {16{8'h03}});
    check("r2_busy_e2", 128'(bsy[1]), 128'd1);
    ordy[1] = 1'b1;
    tick();
    ordy[1] = 1'b0;
    check("r2_busy_after", 128'(bsy[1]), 128'd0);
    check("r2_valid_after", 128'(ov[1]), 128'd0);
    check("r2_ops_after", 128'(ops_of(1)), 128'd1);
    check("r2_ready_after", 128'(ir[1]), 128'd1);

    // 16-bit, ROUNDS=2 table
    for (int i = 0; i < 7; i++) begin
      s_idat = tbl[i].data;
      s_ikey = tbl[i].key;
      s_ied  = tbl[i].dec;
      s_iv   = 1'b1;
      tick();
      s_iv   = 1'b0;
      s_idat = 16'hdead;
      s_ikey = 16'hbeef;
      lat = 0;
      while (!s_ov && lat < TO) begin
        tick();
        lat++;
      end
      check($sformatf("tbl%0d_latency", i), 128'(lat), 128'd2);
      check($sformatf("tbl%0d_data", i), 128'(s_odat), 128'(tbl[i].exp));
      check($sformatf("tbl%0d_mode", i), 128'(s_oed), 128'(tbl[i].dec));
      s_ordy = 1'b1;
      tick();
      s_ordy = 1'b0;
      check($sformatf("tbl%0d_ops", i), 128'(s_ops), 128'(i + 1));
    end

    // Default config: encrypt/decrypt round trips
    for (int n = 0; n < 20; n++) begin
      x  = {$urandom(), $urandom(), $urandom(), $urandom()};
      kk = {$urandom(), $urandom(), $urandom(), $urandom()};
      run(2, x, kk, 1'b0, res, red, lat);
      check($sformatf("rt%0d_enc", n), res, model_enc(x, kk, 10));
      check($sformatf("rt%0d_enc_mode", n), 128'(red), 128'd0);
      run(2, res, kk, 1'b1, rec, red, lat);
      check($sformatf("rt%0d_dec", n), rec, x);
      check($sformatf("rt%0d_dec_mode", n), 128'(red), 128'd1);
    end
    check("rt_ops", 128'(ops_of(2)), 128'd40);

    // Backpressure in HOLD
    x    = 128'h00112233445566778899aabbccddeeff;
    kk   = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    expd = model_enc(x, kk, 10);
    send(2, x, kk, 1'b0);
    wait_out(2, lat);
    check("bp_latency", 128'(lat), 128'd10);
    for (int i = 0; i < 7; i++) begin
      iv[2]   = (i % 2 == 0);
      idat[2] = ~x;
      tick();
      check($sformatf("bp%0d_valid", i), 128'(ov[2]), 128'd1);
      check($sformatf("bp%0d_data", i), odat[2], expd);
      check($sformatf("bp%0d_ready", i), 128'(ir[2]), 128'd0);
      check($sformatf("bp%0d_ops", i), 128'(ops_of(2)), 128'd40);
    end
    iv[2]   = 1'b0;
    ordy[2] = 1'b1;
    tick();
    ordy[2] = 1'b0;
    check("bp_valid_after", 128'(ov[2]), 128'd0);
    check("bp_ops_after", 128'(ops_of(2)), 128'd41);
    check("bp_ready_after", 128'(ir[2]), 128'd1);
    tick();
    check("bp_no_stray_accept", 128'(bsy[2]), 128'd0);

    // Reset mid-RUN
    send(3, x, kk, 1'b0);
    tick();
    tick();
    tick();
    check("mr_busy_before", 128'(bsy[3]), 128'd1);
    reset  = 1'b1;
    iv[3]  = 1'b1;
    tick();
    reset  = 1'b0;
    iv[3]  = 1'b0;
    check("mr_valid", 128'(ov[3]), 128'd0);
    check("mr_busy", 128'(bsy[3]), 128'd0);
    check("mr_ready", 128'(ir[3]), 128'd1);
    check("mr_ops", 128'(ops_of(3)), 128'd0);
    check("mr_data", odat[3], 128'd0);
    x  = 128'hfedcba98765432100123456789abcdef;
    kk = 128'h13579bdf02468ace13579bdf02468ace;
    run(3, x, kk, 1'b0, res, red, lat);
    check("mr_fresh_data", res, model_enc(x, kk, 10));
    check("mr_fresh_ops", 128'(ops_of(3)), 128'd1);

    // CNT_W=4 wrap with back-to-back traffic
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("wr_ops_start", 128'(ops_of(3)), 128'd0);
    cyc  = 0;
    acc  = 0;
    hand = 0;
    last = -1;
    iv[3]   = 1'b1;
    ordy[3] = 1'b1;
    idat[3] = 128'd1;
    ikey[3] = 128'd7;
    ied[3]  = 1'b0;
    while (hand < 17 && cyc < 17 * 12 + 40) begin
      if (ir[3] && iv[3]) begin
        if (last >= 0) check($sformatf("wr_spacing_%0d", acc), 128'(cyc - last), 128'd12);
        last = cyc;
        acc++;
      end
      if (ov[3] && ordy[3]) hand++;
      tick();
      cyc++;
      idat[3] = idat[3] + 128'd1;
      if (acc == 17) iv[3] = 1'b0;
    end
    ordy[3] = 1'b0;
    iv[3]   = 1'b0;
    check("wr_handoffs", 128'(hand), 128'd17);
    check("wr_ops_wrapped", 128'(ops_of(3)), 128'd1);
    check("wr_idle", 128'(bsy[3]), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
